// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - memory-mapped interval timer with sticky interrupt and system tick
//
// Purpose:
//   Interval timer on the MEM-stage data bus. Software loads a reload value
//   (TH) and a counter (TL) and enables counting through TCON. Each timer tick
//   increments TL; when TL is all-ones the next tick reloads it from TH and,
//   if interrupts are enabled, sets the sticky IS flag. IRQ is IE & IS taken
//   straight from flops. A free-running SYSTICK counter advances every clock.
//
// Register map (byte offsets from BASE_ADDR):
//   +0x0  TH       reload value                      R/W
//   +0x4  TL       counter                           R/W
//   +0x8  TCON     bit0 EN, bit1 IE, bit2 IS         R/W (IS: write 0 clears, 1 ignored)
//   +0xC  SYSTICK  free-running cycle counter        RO
//
// Ports:
//   clk        in   1   core clock
//   reset      in   1   asynchronous active-low reset
//   Addr       in  32   byte address (ALU result, MEM stage)
//   WriteData  in  32   store data
//   MemRead    in   1   load strobe
//   MemWrite   in   1   store strobe
//   ReadData   out 32   load data, combinational, 0 unless MemRead && Hit
//   Hit        out  1   Addr decodes to one of the four registers
//   IRQ        out  1   interrupt request to the control decoder

module timer_irq #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        IRQ
);

    // Last value of the prescale counter; a tick fires on this count.
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    localparam logic [1:0] SEL_TH      = 2'd0;
    localparam logic [1:0] SEL_TL      = 2'd1;
    localparam logic [1:0] SEL_TCON    = 2'd2;
    localparam logic [1:0] SEL_SYSTICK = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic        r_en;
    logic        r_ie;
    logic        r_is;
    logic [31:0] r_systick;
    logic [15:0] r_pre;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // Decoding on the offset from BASE_ADDR rather than on raw address bits
    // keeps the window exact: addresses 16 bytes above or below the base
    // cannot alias onto a register. BASE_ADDR is word aligned, so the low
    // two offset bits equal Addr[1:0].
    logic [31:0] w_offset;
    logic [1:0]  w_sel;
    logic        w_hit;

    assign w_offset = Addr - BASE_ADDR;
    assign w_sel    = w_offset[3:2];
    assign w_hit    = (w_offset[31:4] == 28'd0) && (w_offset[1:0] == 2'b00);
    assign Hit      = w_hit;

    logic w_wr;
    logic w_wr_th;
    logic w_wr_tl;
    logic w_wr_tcon;

    assign w_wr      = MemWrite && w_hit;
    assign w_wr_th   = w_wr && (w_sel == SEL_TH);
    assign w_wr_tl   = w_wr && (w_sel == SEL_TL);
    assign w_wr_tcon = w_wr && (w_sel == SEL_TCON);
    // SYSTICK writes decode to nothing and are dropped.

    // ------------------------------------------------------------------
    // Prescaler and tick generation
    // ------------------------------------------------------------------
    logic w_en_rise;
    logic w_tick;
    logic w_ovf;

    // Enabling from the stopped state restarts the prescale period so the
    // first tick after enable is a full PRESCALE clocks away.
    assign w_en_rise = w_wr_tcon && WriteData[0] && !r_en;
    // Tick and overflow use the current (pre-write) EN/TL values; a write in
    // the same edge only changes what happens from the next edge onwards.
    assign w_tick    = r_en && (r_pre == PRE_LAST);
    assign w_ovf     = w_tick && (r_tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= 16'd0;
        end else if (w_en_rise) begin
            r_pre <= 16'd0;
        end else if (r_en) begin
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // TH: plain register. A write racing a reload does not affect the
    // reload, because TL samples r_th before this edge updates it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th <= 32'd0;
        end else if (w_wr_th) begin
            r_th <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // TL: software write has priority over both increment and reload.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tl <= 32'd0;
        end else if (w_wr_tl) begin
            r_tl <= WriteData;
        end else if (w_ovf) begin
            r_tl <= r_th;
        end else if (w_tick) begin
            r_tl <= r_tl + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // TCON control bits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en <= 1'b0;
            r_ie <= 1'b0;
        end else if (w_wr_tcon) begin
            r_en <= WriteData[0];
            r_ie <= WriteData[1];
        end
    end

    // IS is sticky. Setting on overflow is checked first so that a clear
    // landing on the overflow edge cannot drop the interrupt. The overflow
    // is counted even when a TL write overrides the reload in that edge.
    // Software can only clear IS, never set it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is <= 1'b0;
        end else if (w_ovf && r_ie) begin
            r_is <= 1'b1;
        end else if (w_wr_tcon && !WriteData[2]) begin
            r_is <= 1'b0;
        end
    end

    // Both inputs are flops, so IRQ is glitch-free; clearing IE masks the
    // request while leaving IS pending.
    assign IRQ = r_ie & r_is;

    // ------------------------------------------------------------------
    // SYSTICK: free-running, independent of EN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_systick <= 32'd0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux: side-effect free, zero when not selected.
    // ------------------------------------------------------------------
    always_comb begin
        ReadData = 32'd0;
        if (MemRead && w_hit) begin
            case (w_sel)
                SEL_TH:      ReadData = r_th;
                SEL_TL:      ReadData = r_tl;
                SEL_TCON:    ReadData = {29'd0, r_is, r_ie, r_en};
                SEL_SYSTICK: ReadData = r_systick;
                default:     ReadData = 32'd0;
            endcase
        end
    end

endmodule
